// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : button_event_decoder_pkg                                         |
// | Brief  : Shared state encoding, default timing and popcount helper for    |
// |          the push-button event decoder.                                   |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM_P   = 3'd1,
        ST_PRESSED = 3'd2,
        ST_HELD    = 3'd3,
        ST_ARM_R   = 3'd4
    } btn_state_t;

    // 10 ms debounce and 1 s long-press at the 55 MHz platform clock
    localparam int DEB_10MS_55M = 550000;
    localparam int LONG_1S_55M  = 55000000;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : btn_debounce_fsm                                                 |
// | Brief  : One button: 2-flop synchroniser, press/release debounce and      |
// |          long-press timing, with registered level and event pulses.       |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module btn_debounce_fsm
    import button_event_decoder_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_10MS_55M,
    parameter int LONG_CYCLES = LONG_1S_55M
) (
    input  logic clk1,
    input  logic rstn,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic long_pulse,
    output logic release_pulse,
    output logic short_pulse
);

    localparam int              c_tw        = $clog2(LONG_CYCLES + 1);
    localparam logic [c_tw-1:0] c_deb_last  = c_tw'(DEB_CYCLES - 1);
    localparam logic [c_tw-1:0] c_long_last = c_tw'(LONG_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    btn_state_t      r_state;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] r_timer_r;
    logic            r_held;
    logic            w_s;

    assign w_s = ~r_sync2;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_timer_r     <= '0;
            r_held        <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
        end else begin
            r_sync1       <= btn_n;
            r_sync2       <= r_sync1;
            press_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        r_state <= ST_ARM_P;
                        r_timer <= '0;
                    end
                end
                ST_ARM_P: begin
                    if (!w_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_timer == c_deb_last) begin
                        r_state     <= ST_PRESSED;
                        r_timer     <= '0;
                        press_pulse <= 1'b1;
                        level       <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Long expiry takes priority over a release that starts this cycle
                    if (r_timer == c_long_last) begin
                        r_state    <= ST_HELD;
                        long_pulse <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (!w_s) begin
                            r_state   <= ST_ARM_R;
                            r_held    <= 1'b0;
                            r_timer_r <= '0;
                        end
                    end
                end
                ST_HELD: begin
                    if (!w_s) begin
                        r_state   <= ST_ARM_R;
                        r_held    <= 1'b1;
                        r_timer_r <= '0;
                    end
                end
                ST_ARM_R: begin
                    // Saturate so a bounced release can still raise long exactly once
                    if (!r_held && (r_timer != c_long_last)) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (w_s) begin
                        r_state <= r_held ? ST_HELD : ST_PRESSED;
                    end else if (r_timer_r == c_deb_last) begin
                        r_state       <= ST_IDLE;
                        release_pulse <= 1'b1;
                        short_pulse   <= ~r_held;
                        level         <= 1'b0;
                    end else begin
                        r_timer_r <= r_timer_r + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    level   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : button_event_decoder                                             |
// | Brief  : Debounces NUM_BTN active-low buttons, decodes press/long/release |
// |          events and counts completed short presses.                       |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int DEB_CYCLES  = DEB_10MS_55M,
    parameter int LONG_CYCLES = LONG_1S_55M,
    parameter int CNT_W       = 8
) (
    input  logic               clk1,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               count_clr,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [CNT_W-1:0]   evt_count
);

    logic [NUM_BTN-1:0] w_short;
    logic [7:0]         w_short_ext;
    logic [3:0]         w_pop;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_fsm #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_fsm (
            .clk1          (clk1),
            .rstn          (rstn),
            .btn_n         (btn_n[i]),
            .level         (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .release_pulse (release_pulse[i]),
            .short_pulse   (w_short[i])
        );
    end

    always_comb begin
        w_short_ext              = '0;
        w_short_ext[NUM_BTN-1:0] = w_short;
    end

    assign w_pop = popcount8(w_short_ext);

    // Clear wins over same-cycle increments; those events are dropped
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            evt_count <= '0;
        end else if (count_clr) begin
            evt_count <= '0;
        end else begin
            evt_count <= evt_count + CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_button_event_decoder                                          |
// | Brief  : Directed self-checking bench for button_event_decoder.           |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_button_event_decoder;

    localparam int NB   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int CW   = 4;

    logic          clk1      = 1'b0;
    logic          rstn      = 1'b0;
    logic [NB-1:0] btn_n     = '1;
    logic          count_clr = 1'b0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] long_pulse;
    logic [NB-1:0] release_pulse;
    logic [CW-1:0] evt_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int p_cnt [NB];
    int l_cnt [NB];
    int r_cnt [NB];
    int v_cnt [NB];
    int p_cyc [NB];
    int l_cyc [NB];
    int r_cyc [NB];

    button_event_decoder #(
        .NUM_BTN     (NB),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG),
        .CNT_W       (CW)
    ) dut (
        .clk1          (clk1),
        .rstn          (rstn),
        .btn_n         (btn_n),
        .count_clr     (count_clr),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .long_pulse    (long_pulse),
        .release_pulse (release_pulse),
        .evt_count     (evt_count)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc = cyc + 1;

    // Event recorder: cumulative counts and last-seen cycle per button
    always @(negedge clk1) begin
        for (int i = 0; i < NB; i++) begin
            if (press_pulse[i])   begin p_cnt[i] = p_cnt[i] + 1; p_cyc[i] = cyc; end
            if (long_pulse[i])    begin l_cnt[i] = l_cnt[i] + 1; l_cyc[i] = cyc; end
            if (release_pulse[i]) begin r_cnt[i] = r_cnt[i] + 1; r_cyc[i] = cyc; end
            if (btn_level[i])     v_cnt[i] = v_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic short_press(input logic [NB-1:0] mask);
        btn_n = ~mask;
        tick(10);
        btn_n = '1;
        tick(12);
    endtask

    function automatic int all_outs();
        return int'({btn_level, press_pulse, long_pulse, release_pulse, evt_count});
    endfunction

    initial begin
        int c0, c1, pb, lb, rb, vb;

        // Reset state
        tick(3);
        check("reset_outputs", all_outs(), 0);
        rstn = 1'b1;
        tick(3);
        check("idle_outputs", all_outs(), 0);

        // Clean short press on button 0
        pb = p_cnt[0]; lb = l_cnt[0]; rb = r_cnt[0];
        btn_n[0] = 1'b0;
        tick(6);
        check("t1_no_early_press", int'(press_pulse[0]), 0);
        tick(1);
        check("t1_press_pulse", int'(press_pulse[0]), 1);
        tick(1);
        check("t1_press_one_cycle", int'(press_pulse[0]), 0);
        tick(2);
        check("t1_level_high", int'(btn_level[0]), 1);
        btn_n[0] = 1'b1;
        c1 = cyc;
        tick(12);
        check("t1_release_latency", r_cyc[0] - (c1 + 1), 6);
        check("t1_press_count", p_cnt[0] - pb, 1);
        check("t1_release_count", r_cnt[0] - rb, 1);
        check("t1_no_long", l_cnt[0] - lb, 0);
        check("t1_evt_count", int'(evt_count), 1);
        check("t1_level_low", int'(btn_level[0]), 0);

        // Bounce on button 1: 2-cycle low/high toggling never debounces
        pb = p_cnt[1]; rb = r_cnt[1]; vb = v_cnt[1];
        for (int k = 0; k < 5; k++) begin
            btn_n[1] = 1'b0;
            tick(2);
            btn_n[1] = 1'b1;
            tick(2);
        end
        tick(10);
        check("t2_no_press", p_cnt[1] - pb, 0);
        check("t2_no_release", r_cnt[1] - rb, 0);
        check("t2_level_never", v_cnt[1] - vb, 0);
        check("t2_evt_count", int'(evt_count), 1);

        // Long press on button 2
        pb = p_cnt[2]; lb = l_cnt[2]; rb = r_cnt[2];
        c0 = cyc;
        btn_n[2] = 1'b0;
        tick(40);
        check("t3_press_latency", p_cyc[2] - (c0 + 1), 6);
        check("t3_long_count", l_cnt[2] - lb, 1);
        check("t3_long_delay", l_cyc[2] - p_cyc[2], 20);
        check("t3_level_held", int'(btn_level[2]), 1);
        btn_n[2] = 1'b1;
        c1 = cyc;
        tick(12);
        check("t3_release_latency", r_cyc[2] - (c1 + 1), 6);
        check("t3_long_once", l_cnt[2] - lb, 1);
        check("t3_press_once", p_cnt[2] - pb, 1);
        check("t3_release_once", r_cnt[2] - rb, 1);
        check("t3_evt_unchanged", int'(evt_count), 1);

        // Simultaneous short presses and counter wrap
        short_press(4'hF);
        check("t4_evt_5", int'(evt_count), 5);
        short_press(4'hF);
        check("t4_evt_9", int'(evt_count), 9);
        short_press(4'hF);
        check("t4_evt_13", int'(evt_count), 13);
        short_press(4'h1);
        check("t4_evt_14", int'(evt_count), 14);
        short_press(4'hF);
        check("t4_evt_wrap", int'(evt_count), 2);

        // count_clr coinciding with a short release
        btn_n[3] = 1'b0;
        tick(10);
        btn_n[3] = 1'b1;
        tick(7);
        check("t5_release_now", int'(release_pulse[3]), 1);
        count_clr = 1'b1;
        tick(1);
        count_clr = 1'b0;
        check("t5_clear_wins", int'(evt_count), 0);
        tick(4);
        check("t5_event_dropped", int'(evt_count), 0);

        // Reset during PRESSED with the button kept held
        short_press(4'h2);
        check("t6_evt_before", int'(evt_count), 1);
        btn_n[0] = 1'b0;
        tick(9);
        check("t6_level_before", int'(btn_level[0]), 1);
        rstn = 1'b0;
        #1;
        check("t6_async_reset", all_outs(), 0);
        tick(3);
        check("t6_held_in_reset", all_outs(), 0);
        rstn = 1'b1;
        pb = p_cnt[0]; lb = l_cnt[0];
        tick(6);
        check("t6_no_early_press", int'(press_pulse[0]), 0);
        tick(1);
        check("t6_press_again", int'(press_pulse[0]), 1);
        tick(3);
        btn_n[0] = 1'b1;
        tick(12);
        check("t6_press_count", p_cnt[0] - pb, 1);
        check("t6_no_long", l_cnt[0] - lb, 0);
        check("t6_evt_after", int'(evt_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
